spi_master_xfer: RTL

Parametrised full-duplex SPI master that generalises the team's fixed-mode 8-bit SPI master/tx/rx trio into a single block. Adds:
- configurable word width, bit order, SPI mode (CPOL/CPHA) and SCLK divider;
- an active-low chip select with setup, hold and inter-word gap timing;
- a valid/ready transmit handshake and a one-cycle receive strobe.

It sits between a local controller FSM and the external SPI pins.

---
 rtl/spi_master_xfer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/spi_master_xfer.sv
// rtl/spi_master_xfer.sv - parametrised full-duplex SPI master with CS timing
// Single-word transfers: SETUP -> XFER -> HOLD -> GAP, each phase timed by the SCLK divider.
module spi_master_xfer #(
    parameter int   DATA_W    = 8,
    parameter int   CLK_DIV   = 4,
    parameter logic CPOL      = 1'b0,
    parameter logic CPHA      = 1'b0,
    parameter logic MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              rx_valid_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              busy_o,
    output logic              spi_clk_o,
    output logic              spi_cs_n_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EW = $clog2(2 * DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     div_q;
    logic [EW-1:0]     edge_q;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_data_q, rx_next;
    logic              mosi_q, sclk_q, cs_n_q, rx_valid_q;
    logic              tc, last_edge, leading, sample_edge, shift_edge;

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
        return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    // edge_q holds the number of edges already made, so an even count means the next edge leads
    assign tc          = (div_q == CW'(CLK_DIV - 1));
    assign last_edge   = (edge_q == EW'(2 * DATA_W - 1));
    assign leading     = ~edge_q[0];
    assign sample_edge = (leading != CPHA);
    assign shift_edge  = ~sample_edge & ~(~CPHA & last_edge);
    assign rx_next     = MSB_FIRST ? {rx_sr[DATA_W-2:0], spi_miso_i} : {spi_miso_i, rx_sr[DATA_W-1:1]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (tx_valid_i)      state_d = S_SETUP;
            S_SETUP: if (tc)              state_d = S_XFER;
            S_XFER:  if (tc && last_edge) state_d = S_HOLD;
            S_HOLD:  if (tc)              state_d = S_GAP;
            S_GAP:   if (tc)              state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            edge_q  <= '0;
            sclk_q  <= CPOL;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= (state_q == S_IDLE || state_d != state_q || tc) ? '0 : div_q + 1'b1;
            if (state_q == S_XFER && tc) begin
                edge_q <= last_edge ? '0 : edge_q + 1'b1;
                sclk_q <= ~sclk_q;
            end else if (state_q != S_XFER) begin
                sclk_q <= CPOL;
            end
            cs_n_q <= !(state_d == S_SETUP || state_d == S_XFER || state_d == S_HOLD);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_sr      <= '0;
            rx_sr      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_valid_i) begin
                        rx_sr <= '0;
                        // CPHA=0 must present bit one before the first edge; CPHA=1 drives it on edge 1
                        if (!CPHA) begin
                            mosi_q <= first_bit(tx_data_i);
                            tx_sr  <= shift_out(tx_data_i);
                        end else begin
                            mosi_q <= 1'b0;
                            tx_sr  <= tx_data_i;
                        end
                    end
                end
                S_XFER: begin
                    if (tc) begin
                        if (sample_edge) rx_sr <= rx_next;
                        if (shift_edge) begin
                            mosi_q <= first_bit(tx_sr);
                            tx_sr  <= shift_out(tx_sr);
                        end
                        if (last_edge) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= sample_edge ? rx_next : rx_sr;
                        end
                    end
                end
                S_HOLD: if (tc) mosi_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign tx_ready_o = (state_q == S_IDLE);
    assign busy_o     = (state_q != S_IDLE);
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign spi_clk_o  = sclk_q;
    assign spi_cs_n_o = cs_n_q;
    assign spi_mosi_o = mosi_q;

endmodule
